blk_05eeca: RTL and testbench

The `y` block is the 16-bit Y operand register of the gpp_calc datapath. It holds the second ALU operand. It loads the shared 16-bit input bus on a clock edge when its write enable is asserted, and otherwise holds its value. An asynchronous reset clears it, and its contents drive the datapath continuously.

---
 rtl/blk_05eeca.sv | 22 ++
 tb/tb_blk_05eeca.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/blk_05eeca.sv
// Y operand register: 16-bit load-enabled register with asynchronous active-high clear.
module blk_05eeca (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in,
   input  logic        w,
   output logic [15:0] out
);

   logic [15:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (w) begin
         r_q <= in;
      end
   end

   assign out = r_q;

endmodule

// File: tb/tb_blk_05eeca.sv
// Directed bench for the Y operand register: reset, load, hold and back-to-back writes.
module tb_blk_05eeca;

   logic        clk;
   logic        rst;
   logic [15:0] in;
   logic        w;
   logic [15:0] out;

   int errors;
   int checks;

   blk_05eeca dut (
      .clk (clk),
      .rst (rst),
      .in  (in),
      .w   (w),
      .out (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      w   = 1'b1;
      in  = 16'hFFFF;
      @(posedge clk); #1;
      checks++;
      if (out !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_preload: got %h expected %h", out, 16'hFFFF);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL reset_immediate: got %h expected %h", out, 16'h0000);
      end
      w  = 1'b1;
      in = 16'hBCA2;
      @(posedge clk); #1;
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL reset_wins_edge: got %h expected %h", out, 16'h0000);
      end
   endtask

   task automatic test_load();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL release_no_load: got %h expected %h", out, 16'h0000);
      end
      w  = 1'b1;
      in = 16'b1011110010100010;
      @(posedge clk); #1;
      checks++;
      if (out !== 16'hBCA2) begin
         errors++;
         $display("FAIL load_after_release: got %h expected %h", out, 16'hBCA2);
      end
      @(negedge clk); #1;
      checks++;
      if (out !== 16'hBCA2) begin
         errors++;
         $display("FAIL negedge_no_effect: got %h expected %h", out, 16'hBCA2);
      end
      in = 16'h4321;
      #1;
      checks++;
      if (out !== 16'hBCA2) begin
         errors++;
         $display("FAIL no_comb_path: got %h expected %h", out, 16'hBCA2);
      end
   endtask

   task automatic test_mid_reset();
      in = 16'h0007;
      w  = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL mid_reset_immediate: got %h expected %h", out, 16'h0000);
      end
      @(posedge clk); #1;
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL mid_reset_edge: got %h expected %h", out, 16'h0000);
      end
      @(negedge clk);
      rst = 1'b0;
      w   = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL pending_discarded: got %h expected %h", out, 16'h0000);
      end
   endtask

   task automatic test_all_ones();
      @(negedge clk);
      in = 16'hFFFF;
      w  = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out !== 16'hFFFF) begin
         errors++;
         $display("FAIL all_ones_load: got %h expected %h", out, 16'hFFFF);
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      in = 16'b1001010111001101;
      w  = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out !== 16'hFFFF) begin
            errors++;
            $display("FAIL hold_cycle%0d: got %h expected %h", i, out, 16'hFFFF);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [3];
      vals[0] = 16'h1234;
      vals[1] = 16'h5678;
      vals[2] = 16'h0000;
      @(negedge clk);
      w = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         in = vals[i];
         @(posedge clk); #1;
         checks++;
         if (out !== vals[i]) begin
            errors++;
            $display("FAIL back_to_back%0d: got %h expected %h", i, out, vals[i]);
         end
      end
      w  = 1'b0;
      in = 16'hAAAA;
      @(posedge clk); #1;
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL b2b_then_hold: got %h expected %h", out, 16'h0000);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      w   = 1'b0;
      in  = '0;
      #1;
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL initial_reset: got %h expected %h", out, 16'h0000);
      end
      @(posedge clk);
      test_reset();
      test_load();
      test_mid_reset();
      test_all_ones();
      test_hold();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
